// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl - frame-level sequencer for the BCH(63,56) decoder.
//
// Accepts one 63-bit received word per frame (valid/ready), drives the serial
// syndrome unit (clear, enable, wait for done), launches the error locator on
// a non-zero syndrome, applies the single-bit correction and returns the word
// with a status code. Keeps saturating per-outcome statistics.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_word   received-word input handshake
//   synd_clr/synd_en/synd_R     syndrome unit control and latched word
//   synd_done/synd_S            syndrome unit result
//   corr_start/corr_S           error locator launch and syndrome
//   corr_done/corr_pos/corr_fail error locator result
//   out_valid/out_ready         decoded-word output handshake
//   out_word/out_status         decoded word, 00 clean/01 corr/10 uncorr/11 tmo
//   cnt_frames/cnt_corr/cnt_uncorr/cnt_tmo  saturating statistics
module bch_dec_ctrl #(
  parameter int SYND_TIMEOUT = 80,
  parameter int CORR_TIMEOUT = 80,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [62:0]      in_word,
  output logic             synd_clr,
  output logic             synd_en,
  output logic [62:0]      synd_R,
  input  logic             synd_done,
  input  logic [6:0]       synd_S,
  output logic             corr_start,
  output logic [6:0]       corr_S,
  input  logic             corr_done,
  input  logic [5:0]       corr_pos,
  input  logic             corr_fail,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [62:0]      out_word,
  output logic [1:0]       out_status,
  output logic [CNT_W-1:0] cnt_frames,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr,
  output logic [CNT_W-1:0] cnt_tmo
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    SYND = 3'd2,
    CORR = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Watchdog compares against limit-1 because it starts at 0 on the first
  // cycle of the waiting state; the limit-th waiting cycle is the abort cycle.
  localparam logic [7:0] SYND_LIM = 8'(SYND_TIMEOUT - 1);
  localparam logic [7:0] CORR_LIM = 8'(CORR_TIMEOUT - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t            state_r, state_next;
  logic [62:0]       buf_r;
  logic [7:0]        wd_r;
  logic [1:0]        status_r, status_next;
  logic [6:0]        corr_s_r;
  logic              in_ready_r, synd_clr_r, synd_en_r, corr_start_r, out_valid_r;
  logic [CNT_W-1:0]  cnt_frames_r, cnt_corr_r, cnt_uncorr_r, cnt_tmo_r;
  logic              load_s, flip_s, corr_go_s, wd_clr_s, count_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next  = state_r;
    status_next = status_r;
    load_s      = 1'b0;
    flip_s      = 1'b0;
    corr_go_s   = 1'b0;
    wd_clr_s    = 1'b0;
    count_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          load_s     = 1'b1;
          state_next = CLR;
        end else begin
          state_next = IDLE;
        end
      end
      CLR: begin
        wd_clr_s   = 1'b1;
        state_next = SYND;
      end
      SYND: begin
        // done has priority over a watchdog expiring in the same cycle
        if (synd_done) begin
          if (synd_S == 7'd0) begin
            status_next = 2'b00;
            state_next  = OUT;
          end else begin
            corr_go_s  = 1'b1;
            wd_clr_s   = 1'b1;
            state_next = CORR;
          end
        end else if (wd_r == SYND_LIM) begin
          status_next = 2'b11;
          state_next  = OUT;
        end else begin
          state_next = SYND;
        end
      end
      CORR: begin
        if (corr_done) begin
          if (!corr_fail && (corr_pos <= 6'd62)) begin
            flip_s      = 1'b1;
            status_next = 2'b01;
          end else begin
            status_next = 2'b10;
          end
          state_next = OUT;
        end else if (wd_r == CORR_LIM) begin
          status_next = 2'b11;
          state_next  = OUT;
        end else begin
          state_next = CORR;
        end
      end
      OUT: begin
        if (out_valid_r && out_ready) begin
          count_s    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = OUT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath, watchdog and registered handshake/control outputs.
  // Control outputs are decoded from state_next so they are aligned with the
  // state they belong to while still coming straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r        <= 63'd0;
      wd_r         <= 8'd0;
      status_r     <= 2'b00;
      corr_s_r     <= 7'd0;
      in_ready_r   <= 1'b0;
      synd_clr_r   <= 1'b0;
      synd_en_r    <= 1'b0;
      corr_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      if (load_s) begin
        buf_r <= in_word;
      end else if (flip_s) begin
        buf_r <= buf_r ^ (63'd1 << corr_pos);
      end else begin
        buf_r <= buf_r;
      end
      if (wd_clr_s) begin
        wd_r <= 8'd0;
      end else if ((state_r == SYND) || (state_r == CORR)) begin
        wd_r <= wd_r + 8'd1;
      end else begin
        wd_r <= wd_r;
      end
      if (corr_go_s) begin
        corr_s_r <= synd_S;
      end else begin
        corr_s_r <= corr_s_r;
      end
      status_r     <= status_next;
      in_ready_r   <= (state_next == IDLE);
      synd_clr_r   <= (state_next == CLR);
      synd_en_r    <= (state_next == SYND);
      corr_start_r <= corr_go_s;
      out_valid_r  <= (state_next == OUT);
    end
  end

  // Saturating statistics, updated only on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_frames_r <= '0;
      cnt_corr_r   <= '0;
      cnt_uncorr_r <= '0;
      cnt_tmo_r    <= '0;
    end else if (count_s) begin
      cnt_frames_r <= sat_inc(cnt_frames_r);
      case (status_r)
        2'b01:   cnt_corr_r   <= sat_inc(cnt_corr_r);
        2'b10:   cnt_uncorr_r <= sat_inc(cnt_uncorr_r);
        2'b11:   cnt_tmo_r    <= sat_inc(cnt_tmo_r);
        default: cnt_frames_r <= sat_inc(cnt_frames_r);
      endcase
    end else begin
      cnt_frames_r <= cnt_frames_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign synd_clr   = synd_clr_r;
  assign synd_en    = synd_en_r;
  assign synd_R     = buf_r;
  assign corr_start = corr_start_r;
  assign corr_S     = corr_s_r;
  assign out_valid  = out_valid_r;
  assign out_word   = buf_r;
  assign out_status = status_r;
  assign cnt_frames = cnt_frames_r;
  assign cnt_corr   = cnt_corr_r;
  assign cnt_uncorr = cnt_uncorr_r;
  assign cnt_tmo    = cnt_tmo_r;

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb_bch_dec_ctrl - scoreboard bench for bch_dec_ctrl with stub syndrome
// unit and stub error locator. Expected word/status pairs are pushed at
// frame accept; a negedge monitor compares them against the output port.
module tb_bch_dec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [62:0] in_word = 63'd0;
  logic        synd_clr, synd_en;
  logic [62:0] synd_R;
  logic        synd_done;
  logic [6:0]  synd_S;
  logic        corr_start;
  logic [6:0]  corr_S;
  logic        corr_done;
  logic [5:0]  corr_pos;
  logic        corr_fail;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [62:0] out_word;
  logic [1:0]  out_status;
  logic [15:0] cnt_frames, cnt_corr, cnt_uncorr, cnt_tmo;

  bch_dec_ctrl #(.SYND_TIMEOUT(80), .CORR_TIMEOUT(80), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .synd_clr(synd_clr), .synd_en(synd_en), .synd_R(synd_R),
    .synd_done(synd_done), .synd_S(synd_S),
    .corr_start(corr_start), .corr_S(corr_S),
    .corr_done(corr_done), .corr_pos(corr_pos), .corr_fail(corr_fail),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_status(out_status),
    .cnt_frames(cnt_frames), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr), .cnt_tmo(cnt_tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [64:0] sb_q[$];

  // stub configuration
  logic [6:0] stub_s = 7'd0;
  bit         stub_never = 1'b0;
  logic [5:0] stub_pos = 6'd0;
  bit         stub_fail = 1'b0;
  bit         loc_never = 1'b0;

  int e_frames = 0, e_corr = 0, e_uncorr = 0, e_tmo = 0;
  int cyc = 0;
  int en_cyc, done_cyc, valid_cyc;
  bit en_seen, done_seen, valid_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // stub syndrome unit: done after 64 enabled cycles, held until next clear
  int synd_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synd_cnt  <= 0;
      synd_done <= 1'b0;
    end else if (synd_clr) begin
      synd_cnt  <= 0;
      synd_done <= 1'b0;
    end else if (synd_en && !synd_done) begin
      if (!stub_never && synd_cnt == 63) synd_done <= 1'b1;
      synd_cnt <= synd_cnt + 1;
    end
  end
  assign synd_S = synd_done ? stub_s : 7'd0;

  // stub error locator: answers 3 cycles after corr_start
  int loc_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_cnt   <= 0;
      corr_done <= 1'b0;
      corr_pos  <= 6'd0;
      corr_fail <= 1'b0;
    end else begin
      corr_done <= 1'b0;
      if (corr_start && !loc_never) begin
        loc_cnt <= 3;
      end else if (loc_cnt != 0) begin
        loc_cnt <= loc_cnt - 1;
        if (loc_cnt == 1) begin
          corr_done <= 1'b1;
          corr_pos  <= stub_pos;
          corr_fail <= stub_fail;
        end
      end
    end
  end

  // event trackers and scoreboard monitor
  always @(negedge clk) begin
    if (synd_en && !en_seen) begin en_seen = 1'b1; en_cyc = cyc; end
    if (synd_done && !done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
    if (out_valid && !valid_seen) begin valid_seen = 1'b1; valid_cyc = cyc; end
    if (corr_start) chk("corr_S", {57'd0, corr_S}, {57'd0, stub_s});
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        chk("out_word", {1'b0, out_word}, {1'b0, sb_q[0][62:0]});
        chk("out_status", {62'd0, out_status}, {62'd0, sb_q[0][64:63]});
        chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic chk_counters(input string tag);
    chk({tag, "_frames"}, {48'd0, cnt_frames}, 64'(e_frames));
    chk({tag, "_corr"},   {48'd0, cnt_corr},   64'(e_corr));
    chk({tag, "_uncorr"}, {48'd0, cnt_uncorr}, 64'(e_uncorr));
    chk({tag, "_tmo"},    {48'd0, cnt_tmo},    64'(e_tmo));
  endtask

  task automatic accept(input logic [62:0] w);
    for (int i = 0; i < 50 && !in_ready; i++) begin @(posedge clk); #1; end
    chk("accept_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // lat_mode: 0 none, 1 out_valid one cycle after synd_done, 2 eighty SYND cycles
  task automatic run_frame(input string tag, input logic [62:0] w, input logic [6:0] s,
                           input bit never_done, input logic [5:0] pos, input bit fail,
                           input bit lnever, input logic [62:0] ew, input logic [1:0] es,
                           input int stall, input int lat_mode);
    stub_s = s; stub_never = never_done; stub_pos = pos; stub_fail = fail;
    loc_never = lnever;
    out_ready = (stall == 0);
    en_seen = 1'b0; done_seen = 1'b0; valid_seen = 1'b0;
    sb_q.push_back({es, ew});
    accept(w);
    for (int i = 0; i < 400 && !out_valid; i++) begin @(posedge clk); #1; end
    chk({tag, "_valid_wait"}, {63'd0, out_valid}, 64'd1);
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) begin @(posedge clk); #1; end
    chk({tag, "_handshake"}, {63'd0, out_valid}, 64'd0);
    e_frames++;
    if (es == 2'b01) e_corr++;
    if (es == 2'b10) e_uncorr++;
    if (es == 2'b11) e_tmo++;
    chk_counters(tag);
    if (lat_mode == 1) chk({tag, "_lat_done"}, 64'(valid_cyc - done_cyc), 64'd1);
    if (lat_mode == 2) chk({tag, "_lat_tmo"}, 64'(valid_cyc - en_cyc), 64'd80);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_counters("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // reset in the middle of SYND: frame discarded, everything back to 0
    stub_s = 7'd0; stub_never = 1'b0; loc_never = 1'b0;
    accept(63'h5A5A_1234_0F0F_00FF);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_synd_en", {63'd0, synd_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mrst_synd_en", {63'd0, synd_en}, 64'd0);
    chk("mrst_synd_R", {1'b0, synd_R}, 64'd0);
    chk("mrst_out_word", {1'b0, out_word}, 64'd0);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_counters("mrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("clean", 63'd0, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0, 63'd0, 2'b00, 0, 1);
    run_frame("corr17", 63'd1 << 17, 7'h2B, 1'b0, 6'd17, 1'b0, 1'b0, 63'd0, 2'b01, 0, 0);
    run_frame("fail", 63'h0123_4567_89AB_CDEF, 7'h11, 1'b0, 6'd5, 1'b1, 1'b0,
              63'h0123_4567_89AB_CDEF, 2'b10, 0, 0);
    run_frame("pos63", 63'h0000_FFFF_0000_FFFF, 7'h05, 1'b0, 6'd63, 1'b0, 1'b0,
              63'h0000_FFFF_0000_FFFF, 2'b10, 0, 0);
    run_frame("stmo", 63'h7000_0000_0000_0001, 7'd0, 1'b1, 6'd0, 1'b0, 1'b0,
              63'h7000_0000_0000_0001, 2'b11, 0, 2);
    run_frame("ctmo", 63'h0000_0000_DEAD_BEEF, 7'h3C, 1'b0, 6'd0, 1'b0, 1'b1,
              63'h0000_0000_DEAD_BEEF, 2'b11, 0, 0);
    run_frame("stall", 63'h7FFF_FFFF_FFFF_FFFF, 7'h7F, 1'b0, 6'd62, 1'b0, 1'b0,
              63'h3FFF_FFFF_FFFF_FFFF, 2'b01, 20, 0);
    run_frame("bit0", 63'h1234_5678_9ABC_DEF1, 7'h01, 1'b0, 6'd0, 1'b0, 1'b0,
              63'h1234_5678_9ABC_DEF0, 2'b01, 0, 0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
